// File: rtl/data_memory.sv
// data_memory: 32 x 16 single-port data RAM, sync write, async read.
// Optional DATA_MEMORY_REG_OUT_EN registers the read port (1-cycle latency).
module data_memory #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_d_in,
   output logic [DATA_W-1:0] mem_d_out
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] rd_word;

   // next array: one addressed word replaced on write, all others hold
   always_comb begin
      mem_d = mem_q;
      if (mem_wr) begin
         mem_d[mem_addr] = mem_d_in;
      end
   end

   // array state; async reset clears every word and blocks writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   // current contents at the shared address (old data before a write edge)
   always_comb begin
      rd_word = mem_q[mem_addr];
   end

`ifdef DATA_MEMORY_REG_OUT_EN
   logic [DATA_W-1:0] rd_q;
   logic [DATA_W-1:0] rd_d;

   // output register captures pre-write contents each edge
   always_comb begin
      rd_d = rd_word;
   end

   // registered read port, cleared with the array
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q <= '0;
      end else begin
         rd_q <= rd_d;
      end
   end

   assign mem_d_out = rd_q;
`else
   assign mem_d_out = rd_word;
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: vector table, directed corners and random ops vs model.
// Default build checks zero-latency reads; DATA_MEMORY_REG_OUT_EN checks latency 1.
module tb_data_memory;

   logic        clk;
   logic        rst_n;
   logic        mem_wr;
   logic [4:0]  mem_addr;
   logic [15:0] mem_d_in;
   logic [15:0] mem_d_out;

   int n_chk;
   int n_fail;
   logic [15:0] model [32];

   typedef struct {
      logic        wr;
      logic [4:0]  addr;
      logic [15:0] din;
      logic [15:0] exp_pre;
      logic [15:0] exp_post;
   } vec_t;

   vec_t vecs [8];

   data_memory dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_d_in  (mem_d_in),
      .mem_d_out (mem_d_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wr, input logic [4:0] a,
                        input logic [15:0] d);
      mem_wr   = wr;
      mem_addr = a;
      mem_d_in = d;
   endtask

   task automatic read_at(input logic [4:0] a, output logic [15:0] v);
      mem_wr   = 1'b0;
      mem_addr = a;
      #1;
      v = mem_d_out;
   endtask

   initial begin
      logic [15:0] v;
      n_chk  = 0;
      n_fail = 0;
      foreach (model[i]) model[i] = '0;
      drive(1'b0, 5'd17, 16'h0);
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("reset_out", mem_d_out, 16'h0000);
      edge_step();
      edge_step();
      @(negedge clk);
      rst_n = 1'b1;

`ifdef DATA_MEMORY_REG_OUT_EN
      drive(1'b1, 5'd3, 16'h00AA);
      edge_step();
      drive(1'b0, 5'd0, 16'h0);
      edge_step();
      mem_addr = 5'd3;
      #1;
      check("regout_same_cycle", mem_d_out, 16'h0000);
      edge_step();
      check("regout_one_edge", mem_d_out, 16'h00AA);
      mem_addr = 5'd0;
      #1;
      check("regout_hold", mem_d_out, 16'h00AA);
      edge_step();
      check("regout_addr0", mem_d_out, 16'h0000);
      rst_n = 1'b0;
      #1;
      check("regout_reset", mem_d_out, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
`else
      read_at(5'd0, v);  check("post_rst_a0", v, 16'h0000);
      read_at(5'd1, v);  check("post_rst_a1", v, 16'h0000);
      read_at(5'd31, v); check("post_rst_a31", v, 16'h0000);

      vecs[0] = '{1'b0, 5'd0, 16'hDEAD, 16'h0000, 16'h0000};
      vecs[1] = '{1'b0, 5'd1, 16'hBEEF, 16'h0000, 16'h0000};
      vecs[2] = '{1'b1, 5'd1, 16'h000F, 16'h0000, 16'h000F};
      vecs[3] = '{1'b0, 5'd0, 16'h1111, 16'h0000, 16'h0000};
      vecs[4] = '{1'b0, 5'd1, 16'h2222, 16'h000F, 16'h000F};
      vecs[5] = '{1'b1, 5'd1, 16'h0055, 16'h000F, 16'h0055};
      vecs[6] = '{1'b1, 5'd1, 16'h0055, 16'h0055, 16'h0055};
      vecs[7] = '{1'b0, 5'd1, 16'h0000, 16'h0055, 16'h0055};
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].wr, vecs[i].addr, vecs[i].din);
         #1;
         check($sformatf("vec%0d_pre", i), mem_d_out, vecs[i].exp_pre);
         edge_step();
         check($sformatf("vec%0d_post", i), mem_d_out, vecs[i].exp_post);
      end
      read_at(5'd0, v); check("vec_a0_untouched", v, 16'h0000);

      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 5'(i), 16'hA500 + 16'(i));
         edge_step();
      end
      for (int i = 0; i < 32; i++) begin
         read_at(5'(i), v);
         check($sformatf("pattern_a%0d", i), v, 16'hA500 + 16'(i));
      end
      drive(1'b1, 5'd31, 16'hFFFF);
      edge_step();
      for (int i = 0; i < 32; i++) begin
         read_at(5'(i), v);
         check($sformatf("rewrite31_a%0d", i), v,
               (i == 31) ? 16'hFFFF : 16'hA500 + 16'(i));
      end

      drive(1'b1, 5'd5, 16'h1234);
      #1;
      check("midrst_pre", mem_d_out, 16'hA505);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_async", mem_d_out, 16'h0000);
      edge_step();
      check("midrst_held", mem_d_out, 16'h0000);
      mem_wr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      read_at(5'd5, v);  check("midrst_a5", v, 16'h0000);
      read_at(5'd31, v); check("midrst_a31", v, 16'h0000);
      foreach (model[i]) model[i] = '0;

      for (int n = 0; n < 400; n++) begin
         logic        w;
         logic [4:0]  a;
         logic [15:0] d;
         w = 1'($urandom_range(0, 1));
         a = 5'($urandom_range(0, 31));
         d = 16'($urandom);
         drive(w, a, d);
         #1;
         check("rand_pre", mem_d_out, model[a]);
         edge_step();
         if (w) model[a] = d;
         check("rand_post", mem_d_out, model[a]);
      end
      for (int i = 0; i < 32; i++) begin
         read_at(5'(i), v);
         check("rand_final", v, model[i]);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Single-port synchronous-write, asynchronous-read data RAM for the 16-bit processor datapath.
- Default size: 32 words x 16 bits.
- Addressed by the load/store unit; written on the rising clock edge when mem_wr is high.
- The asynchronous reset clears the whole array to zero.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 5, address width in bits.
- DEPTH, 2**ADDR_W (32), number of words. Fixed equal to 2**ADDR_W, so every address is valid.

Ports:
- clk  input  1  system clock; all state changes on the rising edge except reset.
- rst_n  input  1  asynchronous active-low reset.
- mem_wr  input  1  write enable; 1 = write mem_d_in to mem_addr at the next rising edge, 0 = read only.
- mem_addr  input  ADDR_W  word address, shared by read and write.
- mem_d_in  input  DATA_W  write data.
- mem_d_out  output  DATA_W  read data, the word at mem_addr.

Behaviour:
- Storage: DEPTH x DATA_W register array, word-addressed, no byte enables.
- Reset:
  - rst_n low clears all DEPTH words to 0 immediately, without waiting for clk.
  - mem_d_out reads 0 while rst_n is low.
  - Reset has priority over a simultaneous write; no write occurs while rst_n is low.
  - Release of rst_n is synchronised by the integrating design; the block needs no internal synchroniser.
- Write:
  - On a rising clk edge with rst_n=1 and mem_wr=1, mem[mem_addr] <= mem_d_in.
  - Exactly one word is updated; all other words hold.
  - mem_wr=0 leaves the array unchanged.
- Read:
  - Combinational, zero latency: mem_d_out = mem[mem_addr].
  - Follows mem_addr changes within the same cycle, independent of mem_wr.
- Read-during-write, same address:
  - Before the edge, mem_d_out shows the old contents.
  - After the edge, mem_d_out shows the newly written data (old-data-then-new, no bypass).
- Write held high over several edges rewrites the same word each edge; the result is idempotent for constant inputs.
- Address wrap-around: none needed, since the full ADDR_W range maps 1:1 to words.
- X on mem_d_in during a write stores X. X on mem_addr while mem_wr=1 is a bench error and has no defined effect; the RTL does not need to guard it.
- The only state is the array; there are no status outputs.

Optional Feature:
- Macro: DATA_MEMORY_REG_OUT_EN.
- Defined:
  - mem_d_out is driven from an output register loaded on each rising clk edge with mem[mem_addr] (the pre-write contents when writing the same address).
  - Read latency is 1 cycle.
  - The output register resets to 0 asynchronously with rst_n.
- Undefined:
  - Purely combinational read as described in Behaviour, with latency 0.
- Write behaviour is identical in both builds.

Test Plan:
- Reset: drive rst_n=0 with arbitrary mem_addr -> mem_d_out=16'h0000. After release, read addresses 0, 1 and 31 -> all 16'h0000.
- Read-only sweep: mem_wr=0, mem_addr stepped 0 then 1 over several cycles -> mem_d_out stays 16'h0000 and the array is unchanged.
- Write then read:
  - mem_addr=1, mem_d_in=16'h000F, mem_wr=1 for one edge -> mem_d_out becomes 16'h000F after that edge.
  - Then mem_wr=0, mem_addr=0 -> 16'h0000; mem_addr=1 -> 16'h000F.
- Full pattern: write word i with 16'hA500+i for i=0..31, then read all 32 -> each returns 16'hA500+i. Rewrite word 31 with 16'hFFFF -> only word 31 changes.
- Reset mid-operation: with mem_wr=1 writing 16'h1234 to address 5, assert rst_n=0 between edges -> mem_d_out goes to 0 at once. Address 5 reads 16'h0000 after release, and the pending write is not performed.
- DATA_MEMORY_REG_OUT_EN build: write 16'h00AA to address 3, then set mem_addr=3 with mem_wr=0 -> mem_d_out=16'h00AA exactly one edge later, not in the same cycle.
